// File: rtl/final_result_buffer_if.sv
// Result-capture bus: datapath results in, FIFO head and status out.
interface final_result_buffer_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned OP_W   = 2
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic              i_clr;
   logic              i_done;
   logic [DATA_W-1:0] i_data;
   logic [OP_W-1:0]   i_op;
   logic              i_ready;
   logic              o_valid;
   logic [DATA_W-1:0] o_data;
   logic [OP_W-1:0]   o_op;
   logic [DATA_W-1:0] o_last;
   logic [CNT_W-1:0]  o_count;
   logic              o_full;
   logic              o_overflow;

   // Producer/consumer side driving results and ready.
   modport master (
      output i_clr, i_done, i_data, i_op, i_ready,
      input  o_valid, o_data, o_op, o_last, o_count, o_full, o_overflow
   );

   // Buffer side.
   modport slave (
      input  i_clr, i_done, i_data, i_op, i_ready,
      output o_valid, o_data, o_op, o_last, o_count, o_full, o_overflow
   );
endinterface

// File: rtl/final_result_buffer.sv
// Final result buffer: small FIFO of finished results with tag, last-result
// register and sticky overflow flag for results dropped while full.
module final_result_buffer #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned OP_W   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   final_result_buffer_if.slave bus
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] r_mem_data [DEPTH];
   logic [OP_W-1:0]   r_mem_op   [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_overflow;
   logic [DATA_W-1:0] r_last;

   logic w_valid;
   logic w_full;
   logic w_pop;
   logic w_push;
   logic w_drop;

   // Handshake decode from registered occupancy only.
   assign w_valid = (r_count != '0);
   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_pop   = w_valid && bus.i_ready;
   assign w_push  = bus.i_done && (!w_full || w_pop);
   assign w_drop  = bus.i_done && w_full && !w_pop;

   // Pointers, occupancy, overflow flag and last-result register.
   always_ff @(posedge clk) begin
      if (rst || bus.i_clr) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_last     <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (w_drop)      r_overflow <= 1'b1;
         if (bus.i_done)  r_last     <= bus.i_data;
      end
   end

   // Entry storage; never reset, masked on the output while empty.
   always_ff @(posedge clk) begin
      if (!rst && !bus.i_clr && w_push) begin
         r_mem_data[r_wr_ptr] <= bus.i_data;
         r_mem_op[r_wr_ptr]   <= bus.i_op;
      end
   end

   assign bus.o_valid    = w_valid;
   assign bus.o_full     = w_full;
   assign bus.o_count    = r_count;
   assign bus.o_overflow = r_overflow;
   assign bus.o_last     = r_last;
   assign bus.o_data     = w_valid ? r_mem_data[r_rd_ptr] : '0;
   assign bus.o_op       = w_valid ? r_mem_op[r_rd_ptr]   : '0;
endmodule

// File: tb/tb_final_result_buffer.sv
// Directed bench for final_result_buffer with hand-computed expectations.
module tb_final_result_buffer;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned OP_W   = 2;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   final_result_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OP_W(OP_W)) bus ();

   final_result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OP_W(OP_W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.i_clr   = 1'b0;
      bus.i_done  = 1'b0;
      bus.i_data  = '0;
      bus.i_op    = '0;
      bus.i_ready = 1'b0;
   endtask

   task automatic push(input logic [15:0] d, input logic [1:0] op);
      bus.i_done = 1'b1;
      bus.i_data = d;
      bus.i_op   = op;
      step();
      bus.i_done = 1'b0;
   endtask

   task automatic clear();
      bus.i_clr = 1'b1;
      step();
      bus.i_clr = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"},    32'(bus.o_valid),    32'h0);
      check({tag, "_data"},     32'(bus.o_data),     32'h0);
      check({tag, "_op"},       32'(bus.o_op),       32'h0);
      check({tag, "_count"},    32'(bus.o_count),    32'h0);
      check({tag, "_full"},     32'(bus.o_full),     32'h0);
      check({tag, "_overflow"}, 32'(bus.o_overflow), 32'h0);
      check({tag, "_last"},     32'(bus.o_last),     32'h0);
   endtask

   // Pop the head one entry per cycle, checking data against expectation.
   task automatic drain_expect(input string tag, input logic [15:0] exp_d);
      check(tag, 32'(bus.o_data), 32'(exp_d));
      bus.i_ready = 1'b1;
      step();
      bus.i_ready = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      idle();
      rst = 1'b1;
      step();
      step();
      check_zero("reset");
      rst = 1'b0;

      // Single result, visible one cycle after the strobe.
      push(16'h1234, 2'd1);
      check("single_valid", 32'(bus.o_valid), 32'h1);
      check("single_data",  32'(bus.o_data),  32'h1234);
      check("single_op",    32'(bus.o_op),    32'h1);
      check("single_count", 32'(bus.o_count), 32'h1);
      check("single_last",  32'(bus.o_last),  32'h1234);
      clear();
      check("clr_count", 32'(bus.o_count), 32'h0);

      // Fill past capacity: fifth result dropped.
      for (int i = 1; i <= 5; i++) push(16'(i), 2'(i));
      check("ovf_full",     32'(bus.o_full),     32'h1);
      check("ovf_count",    32'(bus.o_count),    32'h4);
      check("ovf_overflow", 32'(bus.o_overflow), 32'h1);
      check("ovf_last",     32'(bus.o_last),     32'h5);
      check("ovf_head_op",  32'(bus.o_op),       32'h1);
      for (int i = 1; i <= 4; i++) drain_expect("ovf_drain", 16'(i));
      check("ovf_empty_valid", 32'(bus.o_valid),    32'h0);
      check("ovf_empty_data",  32'(bus.o_data),     32'h0);
      check("ovf_sticky",      32'(bus.o_overflow), 32'h1);
      // Ready while empty does nothing.
      bus.i_ready = 1'b1;
      step();
      bus.i_ready = 1'b0;
      check("empty_pop_count", 32'(bus.o_count), 32'h0);
      clear();
      check("clr_overflow", 32'(bus.o_overflow), 32'h0);

      // Push and pop together while full.
      for (int i = 0; i < 4; i++) push(16'h10 + 16'(i), 2'd0);
      bus.i_ready = 1'b1;
      push(16'h00AA, 2'd2);
      bus.i_ready = 1'b0;
      check("fullpp_count",    32'(bus.o_count),    32'h4);
      check("fullpp_overflow", 32'(bus.o_overflow), 32'h0);
      check("fullpp_full",     32'(bus.o_full),     32'h1);
      drain_expect("fullpp_drain", 16'h11);
      drain_expect("fullpp_drain", 16'h12);
      drain_expect("fullpp_drain", 16'h13);
      check("fullpp_last_op", 32'(bus.o_op), 32'h2);
      drain_expect("fullpp_drain", 16'h00AA);
      check("fullpp_empty", 32'(bus.o_valid), 32'h0);

      // Streaming with ready held high across two pointer wraps.
      bus.i_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         push(16'(i), 2'(i));
         check("stream_data",  32'(bus.o_data),  32'(i));
         check("stream_count", 32'(bus.o_count), 32'h1);
      end
      step();
      bus.i_ready = 1'b0;
      check("stream_end_count", 32'(bus.o_count), 32'h0);

      // Clear wins over a simultaneous result.
      for (int i = 0; i < 5; i++) push(16'h40 + 16'(i), 2'd1);
      bus.i_ready = 1'b1;
      step();
      bus.i_ready = 1'b0;
      check("pre_clr_count",    32'(bus.o_count),    32'h3);
      check("pre_clr_overflow", 32'(bus.o_overflow), 32'h1);
      bus.i_clr = 1'b1;
      push(16'h0055, 2'd3);
      bus.i_clr = 1'b0;
      check_zero("clr_prio");

      // Reset mid-stream overrides a strobe, then normal latency resumes.
      push(16'h21, 2'd1);
      push(16'h22, 2'd2);
      check("pre_rst_count", 32'(bus.o_count), 32'h2);
      rst = 1'b1;
      bus.i_ready = 1'b1;
      push(16'h99, 2'd3);
      bus.i_ready = 1'b0;
      rst = 1'b0;
      check_zero("mid_rst");
      push(16'h77, 2'd3);
      check("post_rst_valid", 32'(bus.o_valid), 32'h1);
      check("post_rst_data",  32'(bus.o_data),  32'h77);
      check("post_rst_op",    32'(bus.o_op),    32'h3);
      check("post_rst_count", 32'(bus.o_count), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/final_result_buffer.md
FINAL_RESULT_BUFFER -- requirements
Module: final_result_buffer

Interface
REQ-001 Parameter DATA_W, default 16, width of one captured result word.
REQ-002 Parameter DEPTH, default 4, number of result entries buffered; SHALL be a power of two >= 2.
REQ-003 Parameter OP_W, default 2, width of the operation tag stored with each result (mult/div/root/...).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 i_clr  input  1  synchronous flush of buffer, overflow flag and last-result register.
REQ-007 i_done  input  1  one-cycle strobe: i_data/i_op carry a finished result.
REQ-008 i_data  input  DATA_W  result word from the datapath.
REQ-009 i_op  input  OP_W  operation tag of the result.
REQ-010 i_ready  input  1  downstream accepts the head entry this cycle.
REQ-011 o_valid  output  1  buffer non-empty; head entry presented.
REQ-012 o_data  output  DATA_W  head entry data; 0 when empty.
REQ-013 o_op  output  OP_W  head entry tag; 0 when empty.
REQ-014 o_last  output  DATA_W  most recent i_data seen with i_done, independent of draining.
REQ-015 o_count  output  $clog2(DEPTH+1)  number of occupied entries.
REQ-016 o_full  output  1  o_count == DEPTH.
REQ-017 o_overflow  output  1  sticky: a result was dropped because the buffer was full.

Function
REQ-018 Push SHALL occur when i_done=1 and (o_full=0 or pop occurs in the same cycle).
REQ-019 Pop SHALL occur when o_valid=1 and i_ready=1; head advances on that edge.
REQ-020 Pushed entry SHALL become visible on o_data/o_op/o_valid one cycle after i_done (no combinational bypass).
REQ-021 Entries SHALL be delivered in strict arrival order (FIFO).
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; o_count SHALL be exact across wrap.
REQ-023 Simultaneous push and pop SHALL leave o_count unchanged, including when full.
REQ-024 i_done while full without pop SHALL drop the result, leave buffer contents unchanged, and set o_overflow on the next edge.
REQ-025 o_overflow SHALL remain set until rst or i_clr.
REQ-026 o_last SHALL load i_data on every i_done, including dropped results, and otherwise hold.
REQ-027 i_ready while empty SHALL have no effect.
REQ-028 i_clr SHALL empty the buffer, clear o_overflow and o_last to 0, and take priority over a simultaneous i_done or pop, both of which are discarded.
REQ-029 o_valid, o_full, o_count SHALL be derived from registered state only.

Reset
REQ-030 rst=1 SHALL, on the next rising edge, set pointers and o_count to 0, o_valid=0, o_full=0, o_overflow=0, o_last=0, o_data=0, o_op=0.
REQ-031 rst SHALL override i_clr, i_done and i_ready; reset asserted mid-stream SHALL discard all buffered entries.
REQ-032 Entry storage contents need not be reset, but SHALL never be visible while o_valid=0.

Verification
REQ-033 Reset then single i_done with i_data=0x1234, i_op=1, i_ready=0 -> next cycle o_valid=1, o_data=0x1234, o_op=1, o_count=1, o_last=0x1234.
REQ-034 DEPTH=4, i_ready=0, five i_done with data 1..5 -> o_full=1, o_count=4, o_overflow=1, o_last=5; draining yields 1,2,3,4 then o_valid=0.
REQ-035 Full buffer, i_done (data 0xAA) with i_ready=1 same cycle -> o_count stays 4, o_overflow stays 0, 0xAA is emitted last.
REQ-036 Ten push/pop cycles with i_ready=1 continuous and data 0..9 -> output order 0..9, pointers wrap twice, o_count never exceeds 1.
REQ-037 Buffer holding 3 entries with o_overflow=1; i_clr and i_done (0x55) same cycle -> o_count=0, o_valid=0, o_overflow=0, o_last=0.
REQ-038 rst asserted with 2 entries buffered and i_done high -> all outputs 0 next cycle; first push after release delivered with 1-cycle latency.
